// File: rtl/gal_jed_fuse_loader_if.sv
// Byte-stream input and fuse-write output of the JEDEC fuse loader.
// The loader takes the slave side; the byte source and fuse sink take the master side.
interface gal_jed_fuse_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] fuse_addr;
    logic              fuse_val;
    logic              fuse_valid;
    logic              fuse_ready;

    modport master (
        output in_data, in_valid, fuse_ready,
        input  in_ready, fuse_addr, fuse_val, fuse_valid
    );

    modport slave (
        input  in_data, in_valid, fuse_ready,
        output in_ready, fuse_addr, fuse_val, fuse_valid
    );
endinterface

// File: rtl/gal_jed_fuse_loader.sv
// Parses a JEDEC fuse file byte stream into fuse writes and checks the C-field checksum.
// Only L (fuse list) and C (checksum) fields are interpreted; all other fields are skipped.
module gal_jed_fuse_loader #(
    parameter int FUSE_COUNT = 5892,
    parameter int ADDR_W     = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gal_jed_fuse_loader_if.slave  bus,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           cksum,
    output logic                  cksum_ok
);

    localparam logic [7:0] CH_STX  = 8'h02;
    localparam logic [7:0] CH_ETX  = 8'h03;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_C    = 8'h43;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [ADDR_W:0] FUSE_LIM = (ADDR_W+1)'(FUSE_COUNT);

    typedef enum logic [2:0] {
        IDLE, FIELD, SKIP, L_ADDR, L_BITS, C_HEX, DONE, ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              have_digit_q;
    logic [15:0]       hex_acc_q;
    logic [2:0]        hex_cnt_q;
    logic [15:0]       c_val_q;
    logic              c_seen_q;
    logic [ADDR_W-1:0] fuse_addr_q;
    logic              fuse_val_q;
    logic              fuse_valid_q;
    logic [15:0]       cksum_q;
    logic              live_q;

    logic              accept;
    logic              is_ws;
    logic              is_dig;
    logic              is_hex;
    logic [3:0]        nibble;
    logic              in_range;
    logic [ADDR_W-1:0] addr_x10;
    logic [ADDR_W-1:0] addr_next;

    logic addr_clr, addr_dig, hex_clr, hex_shift, c_latch, fuse_load;

    // live_q keeps in_ready low while reset is held and on the first cycle after it.
    assign bus.in_ready   = live_q && (state_q != DONE) && (state_q != ERR)
                            && !(fuse_valid_q && !bus.fuse_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.fuse_addr  = fuse_addr_q;
    assign bus.fuse_val   = fuse_val_q;
    assign bus.fuse_valid = fuse_valid_q;

    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign cksum    = cksum_q;
    assign cksum_ok = done && c_seen_q && (c_val_q == cksum_q);

    assign is_ws  = (bus.in_data == 8'h0D) || (bus.in_data == 8'h0A)
                 || (bus.in_data == 8'h20) || (bus.in_data == 8'h09);
    assign is_dig = (bus.in_data >= CH_0) && (bus.in_data <= 8'h39);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (is_dig) begin
            is_hex = 1'b1;
            nibble = bus.in_data[3:0];
        end else if (((bus.in_data >= 8'h41) && (bus.in_data <= 8'h46)) ||
                     ((bus.in_data >= 8'h61) && (bus.in_data <= 8'h66))) begin
            is_hex = 1'b1;
            nibble = bus.in_data[3:0] + 4'd9;
        end
    end

    // Decimal accumulate as addr*8 + addr*2 + digit, wrapping at ADDR_W bits.
    assign addr_x10  = {addr_q[ADDR_W-4:0], 3'b000} + {addr_q[ADDR_W-2:0], 1'b0};
    assign addr_next = addr_x10 + ADDR_W'(bus.in_data[3:0]);
    assign in_range  = ({1'b0, addr_q} < FUSE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_clr  = 1'b0;
        addr_dig  = 1'b0;
        hex_clr   = 1'b0;
        hex_shift = 1'b0;
        c_latch   = 1'b0;
        fuse_load = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_data == CH_STX) state_d = FIELD;
                end
                FIELD: begin
                    if (is_ws || bus.in_data == CH_STAR) begin
                        state_d = FIELD;
                    end else if (bus.in_data == CH_L) begin
                        state_d  = L_ADDR;
                        addr_clr = 1'b1;
                    end else if (bus.in_data == CH_C) begin
                        state_d = C_HEX;
                        hex_clr = 1'b1;
                    end else if (bus.in_data == CH_ETX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (bus.in_data == CH_STAR)     state_d = FIELD;
                    else if (bus.in_data == CH_ETX) state_d = DONE;
                end
                L_ADDR: begin
                    if (is_dig)                    addr_dig = 1'b1;
                    else if (is_ws && have_digit_q) state_d = L_BITS;
                    else                           state_d = ERR;
                end
                L_BITS: begin
                    if (bus.in_data == CH_0 || bus.in_data == CH_1) begin
                        if (in_range) fuse_load = 1'b1;
                        else          state_d   = ERR;
                    end else if (bus.in_data == CH_STAR) begin
                        state_d = FIELD;
                    end else if (!is_ws) begin
                        state_d = ERR;
                    end
                end
                C_HEX: begin
                    if (is_hex && hex_cnt_q < 3'd4) begin
                        hex_shift = 1'b1;
                    end else if (bus.in_data == CH_STAR && hex_cnt_q == 3'd4) begin
                        c_latch = 1'b1;
                        state_d = FIELD;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Fuse skid register: a new load and the drain of the previous write may share a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q       <= 1'b0;
            addr_q       <= '0;
            have_digit_q <= 1'b0;
            hex_acc_q    <= 16'h0000;
            hex_cnt_q    <= 3'd0;
            c_val_q      <= 16'h0000;
            c_seen_q     <= 1'b0;
            fuse_addr_q  <= '0;
            fuse_val_q   <= 1'b0;
            fuse_valid_q <= 1'b0;
            cksum_q      <= 16'h0000;
        end else begin
            live_q <= 1'b1;

            if (addr_clr) begin
                addr_q       <= '0;
                have_digit_q <= 1'b0;
            end else if (addr_dig) begin
                addr_q       <= addr_next;
                have_digit_q <= 1'b1;
            end else if (fuse_load) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (hex_clr) begin
                hex_acc_q <= 16'h0000;
                hex_cnt_q <= 3'd0;
            end else if (hex_shift) begin
                hex_acc_q <= {hex_acc_q[11:0], nibble};
                hex_cnt_q <= hex_cnt_q + 3'd1;
            end

            if (c_latch) begin
                c_val_q  <= hex_acc_q;
                c_seen_q <= 1'b1;
            end

            if (fuse_load) begin
                fuse_addr_q  <= addr_q;
                fuse_val_q   <= bus.in_data[0];
                fuse_valid_q <= 1'b1;
                if (bus.in_data[0]) cksum_q <= cksum_q + (16'd1 << addr_q[2:0]);
            end else if (bus.fuse_ready) begin
                fuse_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gal_jed_fuse_loader.sv
// Scoreboard bench for gal_jed_fuse_loader: directed JEDEC streams push expected fuse
// writes into queues, and per-instance monitors pop and compare every accepted write.
module tb_gal_jed_fuse_loader;

    localparam int ADDR_W = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gal_jed_fuse_loader_if #(.ADDR_W(ADDR_W)) m_if ();
    gal_jed_fuse_loader_if #(.ADDR_W(ADDR_W)) s_if ();

    logic        m_done, m_err, m_cksum_ok;
    logic        s_done, s_err, s_cksum_ok;
    logic [15:0] m_cksum, s_cksum;

    gal_jed_fuse_loader #(.FUSE_COUNT(5892), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m_if),
        .done(m_done), .err(m_err), .cksum(m_cksum), .cksum_ok(m_cksum_ok)
    );

    gal_jed_fuse_loader #(.FUSE_COUNT(16), .ADDR_W(ADDR_W)) u_small (
        .clk(clk), .rst_n(rst_n), .bus(s_if),
        .done(s_done), .err(s_err), .cksum(s_cksum), .cksum_ok(s_cksum_ok)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W:0] exp_m[$];
    logic [ADDR_W:0] exp_s[$];

    // Monitors: a write transfers on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        logic [ADDR_W:0] e;
        if (rst_n && m_if.fuse_valid && m_if.fuse_ready) begin
            n_checks++;
            if (exp_m.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL main_write: got addr=%0d val=%0b, required no write",
                         m_if.fuse_addr, m_if.fuse_val);
            end else begin
                e = exp_m.pop_front();
                if ({m_if.fuse_addr, m_if.fuse_val} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL main_write: got addr=%0d val=%0b, required addr=%0d val=%0b",
                             m_if.fuse_addr, m_if.fuse_val, e[ADDR_W:1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [ADDR_W:0] e;
        if (rst_n && s_if.fuse_valid && s_if.fuse_ready) begin
            n_checks++;
            if (exp_s.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL small_write: got addr=%0d val=%0b, required no write",
                         s_if.fuse_addr, s_if.fuse_val);
            end else begin
                e = exp_s.pop_front();
                if ({s_if.fuse_addr, s_if.fuse_val} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL small_write: got addr=%0d val=%0b, required addr=%0d val=%0b",
                             s_if.fuse_addr, s_if.fuse_val, e[ADDR_W:1], e[0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] b, input logic v);
        if (sel) begin
            s_if.in_data  = b;
            s_if.in_valid = v;
        end else begin
            m_if.in_data  = b;
            m_if.in_valid = v;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? s_if.in_ready : m_if.in_ready;
    endfunction

    task automatic send_byte(input bit sel, input logic [7:0] b);
        logic ok;
        int   budget;
        ok     = 1'b0;
        budget = 100;
        drive(sel, b, 1'b1);
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = rdy(sel);
            @(posedge clk);
            #1;
            budget--;
        end
        drive(sel, 8'h00, 1'b0);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_byte: byte 0x%02h not accepted, required acceptance", b);
        end
    endtask

    task automatic applyStimulus(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
    endtask

    task automatic try_reject(input bit sel, input logic [7:0] b, input string name);
        drive(sel, b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput(name, {31'd0, rdy(sel)}, 32'd0);
            @(posedge clk);
            #1;
        end
        drive(sel, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input bit sel, input string name);
        int budget;
        budget = 100;
        while (budget > 0 && (sel ? exp_s.size() : exp_m.size()) != 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput(name, sel ? exp_s.size() : exp_m.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input int addr, input logic val);
        exp_m.push_back({ADDR_W'(addr), val});
    endtask

    task automatic l0_body();
        send_byte(0, 8'h02);
        applyStimulus(0, "L0 1101*");
        send_byte(0, 8'h0D);
        send_byte(0, 8'h0A);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        m_if.fuse_ready = 1'b1;
        s_if.fuse_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready",   {31'd0, m_if.in_ready},   32'd0);
        checkOutput("reset fuse_valid", {31'd0, m_if.fuse_valid}, 32'd0);
        checkOutput("reset fuse_addr",  {19'd0, m_if.fuse_addr},  32'd0);
        checkOutput("reset fuse_val",   {31'd0, m_if.fuse_val},   32'd0);
        checkOutput("reset done",       {31'd0, m_done},          32'd0);
        checkOutput("reset err",        {31'd0, m_err},           32'd0);
        checkOutput("reset cksum",      {16'd0, m_cksum},         32'd0);
        checkOutput("reset cksum_ok",   {31'd0, m_cksum_ok},      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic stream with matching checksum");
        push_m(0, 1); push_m(1, 1); push_m(2, 0); push_m(3, 1);
        l0_body();
        applyStimulus(0, "C000B*");
        send_byte(0, 8'h03);
        wait_drain(0, "t1 drain");
        checkOutput("t1 done",     {31'd0, m_done},       32'd1);
        checkOutput("t1 cksum",    {16'd0, m_cksum},      32'h000B);
        checkOutput("t1 cksum_ok", {31'd0, m_cksum_ok},   32'd1);
        checkOutput("t1 err",      {31'd0, m_err},        32'd0);
        checkOutput("t1 in_ready", {31'd0, m_if.in_ready}, 32'd0);

        $display("[TB] checksum mismatch");
        do_reset();
        push_m(0, 1); push_m(1, 1); push_m(2, 0); push_m(3, 1);
        l0_body();
        applyStimulus(0, "C000C*");
        send_byte(0, 8'h03);
        wait_drain(0, "t2 drain");
        checkOutput("t2 done",     {31'd0, m_done},     32'd1);
        checkOutput("t2 cksum_ok", {31'd0, m_cksum_ok}, 32'd0);

        $display("[TB] no C field");
        do_reset();
        push_m(0, 1); push_m(1, 1); push_m(2, 0); push_m(3, 1);
        l0_body();
        send_byte(0, 8'h03);
        wait_drain(0, "t3 drain");
        checkOutput("t3 done",     {31'd0, m_done},     32'd1);
        checkOutput("t3 cksum",    {16'd0, m_cksum},    32'h000B);
        checkOutput("t3 cksum_ok", {31'd0, m_cksum_ok}, 32'd0);

        $display("[TB] back-pressure on fuse sink");
        do_reset();
        push_m(8, 1); push_m(9, 1);
        send_byte(0, 8'h02);
        applyStimulus(0, "L8 ");
        m_if.fuse_ready = 1'b0;
        send_byte(0, "1");
        drive(0, " ", 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4 stall in_ready",   {31'd0, m_if.in_ready},   32'd0);
            checkOutput("t4 stall fuse_valid", {31'd0, m_if.fuse_valid}, 32'd1);
            checkOutput("t4 stall fuse_addr",  {19'd0, m_if.fuse_addr},  32'd8);
            @(posedge clk);
            #1;
        end
        m_if.fuse_ready = 1'b1;
        applyStimulus(0, " 1*");
        send_byte(0, 8'h03);
        wait_drain(0, "t4 drain");
        checkOutput("t4 cksum", {16'd0, m_cksum}, 32'd3);
        checkOutput("t4 done",  {31'd0, m_done},  32'd1);

        $display("[TB] address range limit on small instance");
        do_reset();
        exp_s.push_back({ADDR_W'(15), 1'b1});
        send_byte(1, 8'h02);
        applyStimulus(1, "L15 11");
        wait_drain(1, "t5 drain");
        checkOutput("t5 err",      {31'd0, s_err},        32'd1);
        checkOutput("t5 done",     {31'd0, s_done},       32'd0);
        checkOutput("t5 cksum",    {16'd0, s_cksum},      32'h0080);
        checkOutput("t5 in_ready", {31'd0, s_if.in_ready}, 32'd0);

        $display("[TB] skipped field followed by L field");
        do_reset();
        push_m(0, 1);
        send_byte(0, 8'h02);
        applyStimulus(0, "N comment with L and 1*L0 1*");
        send_byte(0, 8'h03);
        wait_drain(0, "t6 drain");
        checkOutput("t6 done",  {31'd0, m_done},  32'd1);
        checkOutput("t6 cksum", {16'd0, m_cksum}, 32'd1);
        checkOutput("t6 err",   {31'd0, m_err},   32'd0);

        $display("[TB] bad character inside fuse list");
        do_reset();
        push_m(0, 1);
        send_byte(0, 8'h02);
        applyStimulus(0, "L0 1x");
        wait_drain(0, "t7 drain");
        checkOutput("t7 err",  {31'd0, m_err},  32'd1);
        checkOutput("t7 done", {31'd0, m_done}, 32'd0);

        $display("[TB] reset during fuse list");
        do_reset();
        push_m(0, 1);
        send_byte(0, 8'h02);
        applyStimulus(0, "L0 1");
        wait_drain(0, "t8 drain");
        m_if.fuse_ready = 1'b0;
        send_byte(0, "1");
        @(negedge clk);
        checkOutput("t8 pending", {31'd0, m_if.fuse_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("t8 rst fuse_valid", {31'd0, m_if.fuse_valid}, 32'd0);
        checkOutput("t8 rst fuse_addr",  {19'd0, m_if.fuse_addr},  32'd0);
        checkOutput("t8 rst cksum",      {16'd0, m_cksum},         32'd0);
        checkOutput("t8 rst in_ready",   {31'd0, m_if.in_ready},   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_if.fuse_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t8 after fuse_valid", {31'd0, m_if.fuse_valid}, 32'd0);
        checkOutput("t8 after err",        {31'd0, m_err},           32'd0);

        $display("[TB] short checksum field");
        do_reset();
        send_byte(0, 8'h02);
        applyStimulus(0, "C00B*");
        try_reject(0, 8'h03, "t9 etx rejected");
        checkOutput("t9 err",  {31'd0, m_err},  32'd1);
        checkOutput("t9 done", {31'd0, m_done}, 32'd0);

        $display("[TB] second ETX after done");
        do_reset();
        push_m(0, 1);
        send_byte(0, 8'h02);
        applyStimulus(0, "L0 1*");
        send_byte(0, 8'h03);
        try_reject(0, 8'h03, "t10 etx rejected");
        wait_drain(0, "t10 drain");
        checkOutput("t10 done", {31'd0, m_done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
